// File: rtl/mem_responder.sv
// mem_responder: word-organised memory acting as the responder on the CPU's
// Avalon-style bus. Serves one read or write at a time, stalls the master with
// waitrequest for WAIT_CYCLES extra cycles, applies byte enables on writes,
// flags protocol violations in a sticky error bit and offers a preload port
// for loading program images while the bus is quiet.
//
// state | meaning
// IDLE  | no transfer in flight; accepts a request or a preload write
// WAIT  | transfer latched, counting down the stall cycles
// ACK   | waitrequest low for one cycle; read data valid, write commits on exit
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        error,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]    cnt;

    logic [31:0]   lat_addr;
    logic          lat_write;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic          lat_ok;
    logic [AW-1:0] lat_idx;

    logic [31:0]   mem [DEPTH];

    // Decode works on word offsets so the whole subtraction result takes part
    // in the range compare; BASE_ADDR is word aligned.
    logic [29:0]   bus_off;
    logic          bus_ok;
    logic [AW-1:0] bus_idx;
    logic [29:0]   init_off;
    logic          init_ok;
    logic [AW-1:0] init_idx;

    logic          req;
    logic          valid_req;
    logic          accept;
    logic          entering_ack;
    logic          rd_is_write;
    logic          rd_ok;
    logic [AW-1:0] rd_idx;
    logic          mismatch;
    logic          preload_ok;
    logic          commit;
    logic          err_set;

    // Address decode for the live bus address and the preload address.
    always_comb begin
        bus_off  = address[31:2] - BASE_ADDR[31:2];
        bus_ok   = (bus_off < DEPTH_W) && (address[1:0] == 2'b00);
        bus_idx  = bus_off[AW-1:0];
        init_off = init_addr[31:2] - BASE_ADDR[31:2];
        init_ok  = (init_off < DEPTH_W) && (init_addr[1:0] == 2'b00);
        init_idx = init_off[AW-1:0];
    end

    // Request qualification, transfer bookkeeping and error sources.
    always_comb begin
        req          = read | write;
        valid_req    = read ^ write;
        accept       = (state == IDLE) && valid_req;
        entering_ack = (state_nxt == ACK) && (state != ACK);
        // With no stall cycles ACK is entered straight from IDLE, before the
        // latches hold the request, so the live bus is used in that case.
        rd_is_write  = (state == IDLE) ? write   : lat_write;
        rd_ok        = (state == IDLE) ? bus_ok  : lat_ok;
        rd_idx       = (state == IDLE) ? bus_idx : lat_idx;
        mismatch     = ((state == WAIT) || (state == ACK)) &&
                       ((address    != lat_addr)  ||
                        (write      != lat_write) ||
                        (read       == lat_write) ||
                        (byteenable != lat_be)    ||
                        (writedata  != lat_wdata));
        preload_ok   = init_we && (state == IDLE) && !req;
        commit       = (state == ACK) && lat_write && lat_ok;
        err_set      = (accept && !bus_ok) ||
                       ((state == IDLE) && read && write) ||
                       mismatch ||
                       (init_we && !preload_ok) ||
                       (preload_ok && !init_ok);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (valid_req) begin
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: stall whenever a request is present outside ACK, and
    // throughout reset.
    always_comb begin
        waitrequest = 1'b1;
        if (reset) begin
            waitrequest = req && (state != ACK);
        end
    end

    // Stall down-counter: loaded on accept, stops at 1 when ACK is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= WAIT_LOAD;
        end else if ((state == WAIT) && (cnt != 4'd1)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Capture the request on accept; the transfer runs on these values even
    // if the master misbehaves afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_addr  <= 32'd0;
            lat_write <= 1'b0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            lat_ok    <= 1'b0;
            lat_idx   <= '0;
        end else if (accept) begin
            lat_addr  <= address;
            lat_write <= write;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_ok    <= bus_ok;
            lat_idx   <= bus_idx;
        end
    end

    // Read data is registered on the edge entering ACK; bad addresses and
    // writes return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= 32'd0;
        end else if (entering_ack) begin
            if (!rd_is_write && rd_ok) begin
                readdata <= mem[rd_idx];
            end else begin
                readdata <= 32'd0;
            end
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (err_set) begin
            error <= 1'b1;
        end
    end

    // Memory array: bus writes commit leaving ACK (enabled lanes only),
    // preloads write the full word. The two never coincide since preload
    // requires IDLE. Reset forces IDLE, which drops any pending commit.
    always_ff @(posedge clk) begin
        if (commit && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end else if (preload_ok && init_ok && reset) begin
            mem[init_idx] <= init_data;
        end
    end

endmodule
